vga_box_motion_ctrl: RTL

Per-frame motion sequencer for the VGA box demo. Once per video frame it computes the next top-left position of the box, either bouncing autonomously off the screen edges or following four direction buttons. It sits between the VGA timing generator, which supplies `frame_tick`, and the pixel compositor, which consumes `box_x`/`box_y` inside `tt_um_vga_box_v1`.

---
 rtl/vga_box_pkg.sv | 68 ++++++
 rtl/vga_box_motion_ctrl_sync2.sv | 27 ++
 rtl/vga_box_motion_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/vga_box_pkg.sv
// Shared constants, FSM state type and per-axis motion rule for the VGA box demo.
package vga_box_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int BOX_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE,
    UPD_X,
    UPD_Y,
    DONE
  } motion_state_t;

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
  } axis_t;

  // One axis step: bounce in auto mode, clamped button move in manual mode.
  // Worked at 11 bits so pos+step can never wrap.
  function automatic axis_t axis_next(
    input logic [9:0] pos,
    input logic       dir,
    input logic [2:0] step,
    input logic [9:0] pmax,
    input logic       auto_m,
    input logic       inc,
    input logic       dec
  );
    axis_t       r;
    logic [10:0] p;
    logic [10:0] s;
    logic [10:0] m;
    logic [10:0] sum;
    logic [10:0] dif;
    p     = {1'b0, pos};
    s     = {8'b0, step};
    m     = {1'b0, pmax};
    sum   = p + s;
    dif   = p - s;
    r.pos = pos;
    r.dir = dir;
    if (auto_m) begin
      if (dir) begin
        if (sum >= m) begin
          r.pos = pmax;
          r.dir = 1'b0;
        end else begin
          r.pos = 10'(sum);
        end
      end else begin
        if (p <= s) begin
          r.pos = '0;
          r.dir = 1'b1;
        end else begin
          r.pos = 10'(dif);
        end
      end
    end else if (inc && !dec) begin
      r.pos = (sum > m) ? pmax : 10'(sum);
    end else if (dec && !inc) begin
      r.pos = (p < s) ? '0 : 10'(dif);
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_box_motion_ctrl_sync2.sv
// Parameterized-width two-flop synchronizer, async active-low reset to zero.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture of the asynchronous pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/vga_box_motion_ctrl.sv
// Per-frame box motion sequencer: bounce or button-driven, X then Y, then a valid pulse.
module vga_box_motion_ctrl #(
  parameter int H_ACTIVE = vga_box_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_box_pkg::V_ACTIVE,
  parameter int BOX_SIZE = vga_box_pkg::BOX_SIZE,
  parameter int X0       = 304,
  parameter int Y0       = 224
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       frame_tick,
  input  logic       auto_mode,
  input  logic       pause,
  input  logic [3:0] btn,
  input  logic [1:0] speed,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       busy,
  output logic       pos_valid
);

  import vga_box_pkg::*;

  localparam logic [9:0] XMAX = 10'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0] YMAX = 10'(V_ACTIVE - BOX_SIZE);

  logic [5:0]    w_sync;
  logic          w_auto;
  logic          w_pause;
  logic [3:0]    w_btn;
  logic [2:0]    w_step;
  axis_t         w_nx;
  axis_t         w_ny;
  motion_state_t r_state;
  motion_state_t w_next;
  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic          r_dir_x;
  logic          r_dir_y;

  sync2 #(.WIDTH(6)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   ({auto_mode, pause, btn}),
    .o_q   (w_sync)
  );

  assign w_auto  = w_sync[5];
  assign w_pause = w_sync[4];
  assign w_btn   = w_sync[3:0];
  assign w_step  = {1'b0, speed} + 3'd1;

  // Candidate positions; btn is {up, down, left, right}.
  always_comb begin
    w_nx = axis_next(r_x, r_dir_x, w_step, XMAX, w_auto, w_btn[0], w_btn[1]);
    w_ny = axis_next(r_y, r_dir_y, w_step, YMAX, w_auto, w_btn[2], w_btn[3]);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and status outputs; ena low aborts to IDLE.
  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    pos_valid = 1'b0;
    case (r_state)
      IDLE:  if (frame_tick) w_next = UPD_X;
      UPD_X: begin
        busy   = 1'b1;
        w_next = UPD_Y;
      end
      UPD_Y: begin
        busy   = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        pos_valid = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (!ena) w_next = IDLE;
  end

  // Position/direction registers, committed one axis per state unless paused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= 10'(X0);
      r_y     <= 10'(Y0);
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
    end else if (!w_pause) begin
      if (r_state == UPD_X) begin
        r_x     <= w_nx.pos;
        r_dir_x <= w_nx.dir;
      end
      if (r_state == UPD_Y) begin
        r_y     <= w_ny.pos;
        r_dir_y <= w_ny.dir;
      end
    end
  end

  assign box_x = r_x;
  assign box_y = r_y;
  assign dir_x = r_dir_x;
  assign dir_y = r_dir_y;

endmodule
